// File: rtl/n3_zskip.sv
// Zero-skipping brick packer: drops all-zero words except at brick ends, tags each
// kept word with its in-brick offset and end-of-brick flag, and buffers it in a show-ahead FIFO.
module n3_zskip #(
  parameter int N         = 16,
  parameter int OFFSET_SZ = 4,
  parameter int BRICK_LEN = 16,
  parameter int DEPTH     = 4,
  parameter int CNT_SZ    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [N-1:0]         i_data,
  input  logic                 i_last,
  input  logic                 i_bypass,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [N-1:0]         o_data,
  output logic [OFFSET_SZ-1:0] o_offset,
  output logic                 o_last,
  output logic [CNT_SZ-1:0]    o_skipped
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = N + OFFSET_SZ + 1;
  localparam logic [OFFSET_SZ-1:0] LAST_POS  = OFFSET_SZ'(BRICK_LEN - 1);
  localparam logic [AW:0]          DEPTH_CNT = (AW+1)'(DEPTH);

  logic [OFFSET_SZ-1:0] pos_q, pos_d;
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic [CNT_SZ-1:0]    skipped_q, skipped_d;
  logic [EW-1:0]        mem_q [DEPTH];

  logic          full, empty, accept, brick_end, push, pop;
  logic [EW-1:0] wr_entry, head;

  // Handshake and push decision
  always_comb begin
    full      = (cnt_q == DEPTH_CNT);
    empty     = (cnt_q == '0);
    i_ready   = rst & ~full;
    o_valid   = rst & ~empty;
    accept    = i_valid & i_ready;
    brick_end = (pos_q == LAST_POS) | i_last;
    // a brick end is always kept so every brick carries exactly one o_last entry
    push      = accept & ((|i_data) | i_bypass | brick_end);
    pop       = o_valid & o_ready;
    wr_entry  = {i_data, pos_q, brick_end};
  end

  // Next-state
  always_comb begin
    pos_d = pos_q;
    if (accept) pos_d = brick_end ? '0 : pos_q + 1'b1;
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    skipped_d = skipped_q;
    if (accept && !push && !(&skipped_q)) skipped_d = skipped_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pos_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      skipped_q <= '0;
    end else begin
      pos_q     <= pos_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      skipped_q <= skipped_d;
    end
  end

  // Storage is not reset; outputs are masked while empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_entry;
  end

  always_comb begin
    head      = mem_q[rptr_q];
    o_data    = o_valid ? head[EW-1 -: N]      : '0;
    o_offset  = o_valid ? head[OFFSET_SZ:1]    : '0;
    o_last    = o_valid ? head[0]              : 1'b0;
    o_skipped = skipped_q;
  end
endmodule

// File: tb/tb_n3_zskip.sv
// Randomized + directed bench for n3_zskip; a queue-based brick model predicts
// every FIFO entry, i_ready/o_valid, and the saturating skip count.
module tb_n3_zskip;
  localparam int N = 16, OFFSET_SZ = 4, BRICK_LEN = 4, DEPTH = 4, CNT_SZ = 3;
  localparam int SKIP_MAX = (1 << CNT_SZ) - 1;

  logic                 clk = 1'b0, rst = 1'b0;
  logic                 i_valid = 1'b0, i_ready;
  logic [N-1:0]         i_data = '0;
  logic                 i_last = 1'b0, i_bypass = 1'b0;
  logic                 o_valid, o_ready = 1'b1;
  logic [N-1:0]         o_data;
  logic [OFFSET_SZ-1:0] o_offset;
  logic                 o_last;
  logic [CNT_SZ-1:0]    o_skipped;

  n3_zskip #(.N(N), .OFFSET_SZ(OFFSET_SZ), .BRICK_LEN(BRICK_LEN), .DEPTH(DEPTH), .CNT_SZ(CNT_SZ)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .i_last(i_last), .i_bypass(i_bypass), .o_valid(o_valid), .o_ready(o_ready),
    .o_data(o_data), .o_offset(o_offset), .o_last(o_last), .o_skipped(o_skipped)
  );

  always #5 clk = ~clk;

  typedef struct { int data; int off; int last; } ent_t;
  ent_t exp_q[$];
  int   m_pos = 0, m_skip = 0, pend_pop = 0;
  int   checks = 0, errors = 0;
  bit   rnd_rdy = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one accepted word per edge, brick rules applied directly
  always @(posedge clk) begin
    if (!rst) begin
      exp_q.delete(); m_pos = 0; m_skip = 0;
    end else if (i_valid && (exp_q.size() + pend_pop) < DEPTH) begin
      bit be;
      be = (m_pos == BRICK_LEN - 1) || i_last;
      if (i_data != 0 || i_bypass || be)
        exp_q.push_back('{data: int'(i_data), off: m_pos, last: int'(be)});
      else if (m_skip < SKIP_MAX)
        m_skip++;
      m_pos = be ? 0 : m_pos + 1;
    end
    pend_pop = 0;
  end

  // Monitor: compare visible state, then retire the head if it pops next edge
  always @(negedge clk) begin
    bit ev;
    ev = rst && exp_q.size() > 0;
    chk("o_valid", int'(o_valid), int'(ev));
    chk("i_ready", int'(i_ready), int'(rst && exp_q.size() < DEPTH));
    chk("o_skipped", int'(o_skipped), m_skip);
    if (ev) begin
      chk("o_data", int'(o_data), exp_q[0].data);
      chk("o_offset", int'(o_offset), exp_q[0].off);
      chk("o_last", int'(o_last), exp_q[0].last);
      if (o_ready) begin
        void'(exp_q.pop_front());
        pend_pop = 1;
      end
    end else begin
      chk("idle_zero", int'({o_data, o_offset, o_last}), 0);
    end
  end

  always @(posedge clk) if (rnd_rdy) begin #1; o_ready = ($urandom_range(0, 3) != 0); end

  // Drive one word and hold it until accepted (bounded)
  task automatic send(input int d, input bit last, input bit byp);
    int n = 0;
    i_valid = 1'b1; i_data = N'(d); i_last = last; i_bypass = byp;
    @(negedge clk);
    while (!i_ready && n < 200) begin @(negedge clk); n++; end
    if (!i_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: got i_ready 0 expected 1 at %0t", $time);
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_data = N'($urandom); i_last = 1'b0; i_bypass = 1'b0;
  endtask

  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; idle(1); rst = 1'b1; idle(1);
  endtask

  initial begin
    idle(3);
    rst = 1'b1; idle(1);

    // 0,5,0,7 -> (5,1,0) (7,3,1), two skipped
    send(0, 0, 0); send(5, 0, 0); send(0, 0, 0); send(7, 0, 0);
    idle(4); chk("skip_025", int'(o_skipped), 2);

    // 3,0,0,0 -> (3,0,0) (0,3,1)
    do_reset();
    send(3, 0, 0); send(0, 0, 0); send(0, 0, 0); send(0, 0, 0);
    idle(4); chk("skip_026", int'(o_skipped), 2);

    // i_last brick end returns pos to 0
    do_reset();
    send(0, 0, 0); send(0, 1, 0); send(9, 0, 0);
    idle(4);

    // backpressure: only DEPTH of 6 words enter until draining starts
    do_reset();
    o_ready = 1'b0;
    fork
      begin for (int k = 1; k <= 6; k++) send(k * 11, 0, 0); end
      begin idle(12); chk("full_ready", int'(i_ready), 0); o_ready = 1'b1; end
    join
    idle(6);

    // bypass keeps zeros, then saturate the skip counter
    do_reset();
    for (int k = 0; k < 4; k++) send(0, 0, 1);
    idle(2); chk("skip_bypass", int'(o_skipped), 0);
    for (int k = 0; k < 20; k++) send(0, 0, 0);
    idle(3); chk("skip_sat", int'(o_skipped), SKIP_MAX);

    // reset mid-brick drops everything; next word starts at offset 0
    o_ready = 1'b0;
    send(1, 0, 0); send(2, 0, 0);
    do_reset();
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_skip", int'(o_skipped), 0);
    o_ready = 1'b1;
    send(4, 0, 0);
    idle(4);

    // randomized traffic with random backpressure and gaps
    rnd_rdy = 1;
    for (int k = 0; k < 400; k++) begin
      int d;
      d = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 65535));
      if ($urandom_range(0, 4) == 0) idle(1);
      send(d, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end
    rnd_rdy = 0;
    idle(2);
    o_ready = 1'b1;
    idle(10);
    chk("drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/n3_zskip.md
N3_ZSKIP -- requirements
Module: n3_zskip

Interface
REQ-001 Parameter N, default 16: data word width in bits.
REQ-002 Parameter OFFSET_SZ, default 4: width of the in-brick offset field.
REQ-003 Parameter BRICK_LEN, default 16: words per brick; the legal range is 2 to 2^OFFSET_SZ.
REQ-004 Parameter DEPTH, default 4: output FIFO entries; must be a power of 2 and at least 2.
REQ-005 Parameter CNT_SZ, default 16: width of the skipped-word statistics counter.
REQ-006 Ports, one per line: name, direction, width, meaning.
- clk       input   1          clock; all state changes on its rising edge
- rst       input   1          reset; synchronous, active-low
- i_valid   input   1          input word valid
- i_ready   output  1          block can accept an input word
- i_data    input   N          input word
- i_last    input   1          force end of brick on this word
- i_bypass  input   1          1 = emit zero words as well (no skipping)
- o_valid   output  1          FIFO head valid
- o_ready   input   1          downstream accepts the head entry
- o_data    output  N          head data
- o_offset  output  OFFSET_SZ  head position within its brick
- o_last    output  1          head is the final entry of its brick
- o_skipped output  CNT_SZ     saturating count of dropped zero words

Function
REQ-007 Accept: an input word is accepted when i_valid and i_ready are both 1 at a rising clk edge; i_ready = rst & ~full.
REQ-008 Position counter pos (OFFSET_SZ bits) holds the offset of the next accepted word.
- On accept, pos increments by 1.
- pos returns to 0 when the accepted word is a brick end.
REQ-009 Brick end: the accepted word is a brick end when pos == BRICK_LEN-1 or i_last == 1.
- Both conditions in the same word cause a single brick end.
REQ-010 Push rule: an accepted word is written to the FIFO as {i_data, pos, brick_end} when any of these holds:
- i_data is nonzero;
- i_bypass == 1;
- the word is a brick end.
REQ-011 Consequence of REQ-010: every brick yields at least one entry, and exactly one entry per brick has o_last == 1.
REQ-012 Skip counter: an accepted word that is not pushed increments o_skipped by 1; o_skipped saturates at 2^CNT_SZ-1 and never wraps.
REQ-013 FIFO behaviour:
- Show-ahead, first-in first-out.
- An entry written at edge k is visible on o_valid/o_data/o_offset/o_last after edge k (latency 1 cycle).
- No combinational path from i_data to the outputs.
REQ-014 Pop: the head entry is popped when o_valid and o_ready are both 1 at a rising edge.
REQ-015 o_valid = ~empty.
- While o_valid == 0: o_data, o_offset and o_last are 0.
- While o_valid == 1 and o_ready == 0: the head outputs are held stable.
REQ-016 Full FIFO: i_ready == 0; no word is accepted and pos does not advance.
- A pop in that cycle raises i_ready only in the following cycle.
REQ-017 Simultaneous push and pop when the FIFO is not full: both take effect; occupancy is unchanged and order is preserved.
REQ-018 Occupancy tracking:
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Full and empty are distinguished by an occupancy counter of log2(DEPTH)+1 bits.
REQ-019 i_bypass and i_last are sampled per accepted word; changing i_bypass mid-brick affects only subsequent words.
REQ-020 Input words with i_valid == 0 are ignored; they affect neither pos nor o_skipped.

Reset
REQ-021 Reset takes effect when rst == 0 at a rising clk edge. It clears:
- pos;
- FIFO pointers and occupancy counter;
- o_skipped.
REQ-022 While rst == 0: i_ready == 0 and o_valid == 0.
REQ-023 Reset mid-brick discards the partial brick and all FIFO contents; the first accepted word after rst returns to 1 has offset 0.
REQ-024 FIFO data storage is not reset; outputs are still 0 while empty per REQ-015.

Verification (N=16, BRICK_LEN=4, DEPTH=4, CNT_SZ=3, o_ready=1 unless stated)
REQ-025 Stream 0,5,0,7 with bypass 0:
- Output (5,off1,last0) then (7,off3,last1).
- o_skipped=2.
REQ-026 Stream 3,0,0,0:
- Output (3,off0,last0) then (0,off3,last1).
- o_skipped=2.
REQ-027 Stream 0, then 0 with i_last=1, then 9:
- Output (0,off1,last1) then (9,off0,...).
- The i_last brick end resets pos.
REQ-028 o_ready=0, offer 6 nonzero words:
- Exactly 4 accepted; i_ready=0 from then on.
- Raise o_ready: entries drain in order with offsets 0,1,2,3.
- i_ready returns 1 one cycle after the first pop.
REQ-029 Bypass and saturation:
- i_bypass=1 with stream 0,0,0,0: four entries, offsets 0..3, only the last with o_last=1; o_skipped unchanged.
- Then 20 skipped zero words with bypass 0: o_skipped saturates at 7.
REQ-030 Reset mid-brick: after 2 accepted words, assert rst=0 for one cycle.
- o_valid=0 and o_skipped=0.
- Next word 4 emerges with offset 0.
